// File: rtl/manycore_release_timer_pkg.sv
// Shared types and register offsets for the multi-channel release timer.
package manycore_release_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PENDING  = 2'd2
  } release_state_t;

  localparam logic [3:0] RT_CTRL_OFS   = 4'h0;
  localparam logic [3:0] RT_PERIOD_OFS = 4'h4;
  localparam logic [3:0] RT_NEXT_OFS   = 4'h8;
  localparam logic [3:0] RT_ACK_OFS    = 4'hC;

  function automatic logic [31:0] rt_ack_word(input logic       pending,
                                              input logic [7:0] overrun,
                                              input logic       ack_flip);
    return {15'b0, pending, overrun, 7'b0, ack_flip};
  endfunction

endpackage

// File: rtl/manycore_release_timer_channel.sv
// One release channel: countdown, IDLE/COUNTING/PENDING FSM, overrun count and flip-ack.
module manycore_release_timer_channel
  import manycore_release_timer_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DELAY   = 32'd30_000_000,
  parameter logic [31:0] DEFAULT_PERIOD  = 32'd5_000_000,
  parameter bit          ENABLE_AT_RESET = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_ctrl_i,
  input  logic        wr_period_i,
  input  logic        wr_next_i,
  input  logic        wr_ack_i,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  rd_ofs_i,
  output logic        irq_o,
  output logic [31:0] rd_data_o
);

  release_state_t state_q, state_d;
  logic        enable_q, enable_d;
  logic        oneshot_q, oneshot_d;
  logic [31:0] period_q, period_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  overrun_q, overrun_d;
  logic        ack_flip_q, ack_flip_d;
  logic        expire, ack_toggle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ENABLE_AT_RESET ? COUNTING : IDLE;
      enable_q   <= ENABLE_AT_RESET;
      oneshot_q  <= 1'b0;
      period_q   <= DEFAULT_PERIOD;
      count_q    <= DEFAULT_DELAY;
      overrun_q  <= '0;
      ack_flip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      oneshot_q  <= oneshot_d;
      period_q   <= period_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      ack_flip_q <= ack_flip_d;
    end
  end

  // A NEXT write in the expiry cycle replaces the countdown, so no release happens.
  assign expire     = (state_q != IDLE) && (count_q == 32'd0) && !wr_next_i;
  assign ack_toggle = wr_ack_i && (wr_data_i[0] != ack_flip_q);

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    oneshot_d  = oneshot_q;
    period_d   = period_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    ack_flip_d = ack_flip_q;

    if (wr_next_i)
      count_d = wr_data_i;
    else if (state_q != IDLE)
      count_d = (count_q == 32'd0) ? period_q - 32'd1 : count_q - 32'd1;

    if (wr_period_i)
      period_d = (wr_data_i == 32'd0) ? 32'd1 : wr_data_i;

    if (ack_toggle)
      ack_flip_d = wr_data_i[0];

    case (state_q)
      COUNTING: if (expire) state_d = PENDING;
      PENDING: begin
        // A oneshot channel has already released once; later expiries are not releases.
        if (ack_toggle && (oneshot_q || !expire)) begin
          state_d = oneshot_q ? IDLE : COUNTING;
          if (oneshot_q) enable_d = 1'b0;
        end else if (expire && !ack_toggle && !oneshot_q && overrun_q != 8'hFF) begin
          overrun_d = overrun_q + 8'd1;
        end
      end
      default: ;
    endcase

    if (wr_ctrl_i) begin
      enable_d  = wr_data_i[0];
      oneshot_d = wr_data_i[1];
      if (!wr_data_i[0]) begin
        state_d = IDLE;
      end else begin
        overrun_d = '0;
        if (state_d == IDLE) state_d = COUNTING;
      end
    end
  end

  assign irq_o = (state_q == PENDING);

  always_comb begin
    rd_data_o = '0;
    case ({rd_ofs_i, 2'b00})
      RT_CTRL_OFS:   rd_data_o = {30'b0, oneshot_q, enable_q};
      RT_PERIOD_OFS: rd_data_o = period_q;
      RT_NEXT_OFS:   rd_data_o = count_q;
      RT_ACK_OFS:    rd_data_o = rt_ack_word(state_q == PENDING, overrun_q, ack_flip_q);
      default:       rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/manycore_release_timer.sv
// Multi-channel periodic release timer on the PE MMIO bus: decode, channels, cycle counter, read mux.
module manycore_release_timer
  import manycore_release_timer_pkg::*;
#(
  parameter int          MEMORY_WIDTH   = 32,
  parameter int          NUM_CHANNELS   = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h2000_0100,
  parameter logic [31:0] DEFAULT_DELAY  = 32'd30_000_000,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd5_000_000,
  parameter bit          AUTO_ENABLE    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             addr_in,
  input  logic [MEMORY_WIDTH-1:0] data_in,
  input  logic [3:0]              wb_in,
  output logic [MEMORY_WIDTH-1:0] data_out,
  output logic                    hit_out,
  output logic [NUM_CHANNELS-1:0] irq_out,
  output logic [31:0]             cycle_out
);

  localparam int MAP_WORDS = 4 * NUM_CHANNELS + 1;

  logic [31:0] ofs, word;
  logic [29:0] ch_idx;
  logic [3:0]  reg_ofs;
  logic        in_map, is_cycle, wr_en;
  logic [31:0] wr_data, rd_word;
  logic [31:0] ch_rd [NUM_CHANNELS];

  logic [MEMORY_WIDTH-1:0] data_q;
  logic                    hit_q;
  logic [31:0]             cycle_q;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of the map.
  assign ofs      = addr_in - BASE_ADDR;
  assign word     = ofs >> 2;
  assign ch_idx   = word[31:2];
  assign reg_ofs  = {word[1:0], 2'b00};
  assign in_map   = word < 32'(MAP_WORDS);
  assign is_cycle = word == 32'(4 * NUM_CHANNELS);
  assign wr_en    = (|wb_in) && in_map && !is_cycle;
  assign wr_data  = 32'(data_in);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch_idx == 30'(g));

    manycore_release_timer_channel #(
      .DEFAULT_DELAY   (DEFAULT_DELAY),
      .DEFAULT_PERIOD  (DEFAULT_PERIOD),
      .ENABLE_AT_RESET (AUTO_ENABLE && (g == 0))
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .wr_ctrl_i   (sel && (reg_ofs == RT_CTRL_OFS)),
      .wr_period_i (sel && (reg_ofs == RT_PERIOD_OFS)),
      .wr_next_i   (sel && (reg_ofs == RT_NEXT_OFS)),
      .wr_ack_i    (sel && (reg_ofs == RT_ACK_OFS)),
      .wr_data_i   (wr_data),
      .rd_ofs_i    (word[1:0]),
      .irq_o       (irq_out[g]),
      .rd_data_o   (ch_rd[g])
    );
  end

  always_comb begin
    rd_word = '0;
    if (in_map) begin
      if (is_cycle) begin
        rd_word = cycle_q;
      end else begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          if (ch_idx == 30'(i)) rd_word = ch_rd[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      hit_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      data_q  <= MEMORY_WIDTH'(rd_word);
      hit_q   <= in_map;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign data_out  = data_q;
  assign hit_out   = hit_q;
  assign cycle_out = cycle_q;

endmodule

// File: tb/tb_manycore_release_timer.sv
// Bench for manycore_release_timer with short delay/period so releases happen within a few hundred cycles.
module tb_manycore_release_timer;

  localparam logic [31:0] BASE = 32'h2000_0100;
  localparam logic [3:0]  O_CTRL = 4'h0, O_PERIOD = 4'h4, O_NEXT = 4'h8, O_ACK = 4'hC;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr_in = IDLE_ADDR;
  logic [31:0] data_in = '0;
  logic [3:0]  wb_in = '0;
  logic [31:0] data_out;
  logic        hit_out;
  logic [3:0]  irq_out;
  logic [31:0] cycle_out;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_cyc;
  bit quiet_done = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        hit;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  manycore_release_timer #(
    .MEMORY_WIDTH   (32),
    .NUM_CHANNELS   (4),
    .BASE_ADDR      (BASE),
    .DEFAULT_DELAY  (32'd100),
    .DEFAULT_PERIOD (32'd50),
    .AUTO_ENABLE    (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .wb_in     (wb_in),
    .data_out  (data_out),
    .hit_out   (hit_out),
    .irq_out   (irq_out),
    .cycle_out (cycle_out)
  );

  always #5 clock = ~clock;

  // Bench-owned cycle number: value cycle_out should hold after the same edge.
  always @(posedge clock or posedge reset)
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, tb_cyc);
    end
  endtask

  function automatic logic [31:0] ch_addr(input int ch, input logic [3:0] o);
    return BASE + 32'(16 * ch) + 32'(o);
  endfunction

  function automatic logic [31:0] ack_word(input logic p, input logic [7:0] ov, input logic f);
    return {15'b0, p, ov, 7'b0, f};
  endfunction

  task automatic go_to_cycle(input int n);
    while (tb_cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    addr_in = a;
    data_in = d;
    wb_in   = 4'hF;
    @(posedge clock);
    #1;
    addr_in = IDLE_ADDR;
    wb_in   = 4'h0;
  endtask

  task automatic mmio_rd(input string tag, input logic [31:0] a,
                         input logic [31:0] exp, input logic exp_hit);
    rd_exp_t e;
    e.tag  = tag;
    e.data = exp;
    e.hit  = exp_hit;
    addr_in = a;
    wb_in   = 4'h0;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    addr_in = IDLE_ADDR;
    e = sb_q.pop_front();
    check_eq(e.tag, data_out, e.data);
    check_eq({e.tag, "_hit"}, 32'(hit_out), 32'(e.hit));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_irq",   32'(irq_out), 32'd0);
    check_eq("rst_data",  data_out,     32'd0);
    check_eq("rst_hit",   32'(hit_out), 32'd0);
    check_eq("rst_cycle", cycle_out,    32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    apply_reset();

    // Reset values, read latency and map basics.
    mmio_rd("ch0_ctrl",   ch_addr(0, O_CTRL),   32'd1,  1'b1);
    mmio_rd("ch0_period", ch_addr(0, O_PERIOD), 32'd50, 1'b1);
    mmio_rd("ch1_ctrl",   ch_addr(1, O_CTRL),   32'd0,  1'b1);
    mmio_rd("ch0_next",   ch_addr(0, O_NEXT),   32'(100 - tb_cyc), 1'b1);
    mmio_rd("ch0_ack",    ch_addr(0, O_ACK),    32'd0,  1'b1);
    mmio_rd("cycle",      ch_addr(4, O_CTRL),   32'(tb_cyc), 1'b1);

    // First release and unacked overruns.
    go_to_cycle(100); check_eq("irq0_pre",  32'(irq_out[0]), 32'd0);
    go_to_cycle(101); check_eq("irq0_rise", 32'(irq_out[0]), 32'd1);
    mmio_rd("ack0_p", ch_addr(0, O_ACK), ack_word(1'b1, 8'd0, 1'b0), 1'b1);
    go_to_cycle(151);
    mmio_rd("ack0_ov1", ch_addr(0, O_ACK), ack_word(1'b1, 8'd1, 1'b0), 1'b1);
    go_to_cycle(201);
    mmio_rd("ack0_ov2", ch_addr(0, O_ACK), ack_word(1'b1, 8'd2, 1'b0), 1'b1);

    // Flip-ack, unchanged schedule, repeated ack ignored.
    go_to_cycle(210); check_eq("irq0_b4ack", 32'(irq_out[0]), 32'd1);
    mmio_wr(ch_addr(0, O_ACK), 32'd1);
    check_eq("irq0_acked", 32'(irq_out[0]), 32'd0);
    go_to_cycle(250); check_eq("irq0_pre2",  32'(irq_out[0]), 32'd0);
    go_to_cycle(251); check_eq("irq0_rise2", 32'(irq_out[0]), 32'd1);
    mmio_rd("ack0_f1", ch_addr(0, O_ACK), ack_word(1'b1, 8'd2, 1'b1), 1'b1);
    go_to_cycle(259);
    mmio_wr(ch_addr(0, O_ACK), 32'd1);
    check_eq("irq0_rep_ack", 32'(irq_out[0]), 32'd1);
    mmio_rd("ack0_rep", ch_addr(0, O_ACK), ack_word(1'b1, 8'd2, 1'b1), 1'b1);

    // Oneshot channel 1 with PERIOD=0.
    go_to_cycle(262);
    mmio_wr(ch_addr(1, O_PERIOD), 32'd0);
    mmio_wr(ch_addr(1, O_CTRL),   32'd3);
    mmio_wr(ch_addr(1, O_NEXT),   32'd5);
    go_to_cycle(270); check_eq("irq1_pre",  32'(irq_out[1]), 32'd0);
    go_to_cycle(271); check_eq("irq1_rise", 32'(irq_out[1]), 32'd1);
    mmio_rd("ch1_period1", ch_addr(1, O_PERIOD), 32'd1, 1'b1);
    mmio_rd("ch1_ack_p",   ch_addr(1, O_ACK), ack_word(1'b1, 8'd0, 1'b0), 1'b1);
    mmio_wr(ch_addr(1, O_ACK), 32'd1);
    check_eq("irq1_acked", 32'(irq_out[1]), 32'd0);
    mmio_rd("ch1_ctrl_os", ch_addr(1, O_CTRL), 32'd2, 1'b1);
    fork
      begin
        int hi = 0;
        for (int i = 0; i < 100; i++) begin
          @(posedge clock);
          #1;
          if (irq_out[1]) hi++;
        end
        check_eq("irq1_quiet", 32'(hi), 32'd0);
        quiet_done = 1'b1;
      end
    join_none

    // Ack lands on the expiry edge of a periodic channel.
    go_to_cycle(300);
    mmio_wr(ch_addr(0, O_ACK), 32'd0);
    check_eq("irq0_ack_exp", 32'(irq_out[0]), 32'd1);
    mmio_rd("ack0_ack_exp", ch_addr(0, O_ACK), ack_word(1'b1, 8'd2, 1'b0), 1'b1);

    // Reset while pending with overrun=3.
    go_to_cycle(379);
    mmio_rd("ack0_ov3", ch_addr(0, O_ACK), ack_word(1'b1, 8'd3, 1'b0), 1'b1);
    wait (quiet_done);
    #2;
    apply_reset();
    mmio_rd("cycle_r0",    ch_addr(4, O_CTRL),   32'd0,  1'b1);
    mmio_rd("cycle_r1",    ch_addr(4, O_CTRL),   32'd1,  1'b1);
    mmio_rd("r_ack0",      ch_addr(0, O_ACK),    32'd0,  1'b1);
    mmio_rd("r_next0",     ch_addr(0, O_NEXT),   32'(100 - tb_cyc), 1'b1);
    mmio_rd("r_period0",   ch_addr(0, O_PERIOD), 32'd50, 1'b1);
    mmio_rd("r_ctrl1",     ch_addr(1, O_CTRL),   32'd0,  1'b1);
    mmio_rd("r_period1",   ch_addr(1, O_PERIOD), 32'd50, 1'b1);
    mmio_rd("r_next1",     ch_addr(1, O_NEXT),   32'd100, 1'b1);

    // NEXT write on the expiry edge suppresses the release.
    go_to_cycle(100);
    mmio_wr(ch_addr(0, O_NEXT), 32'd20);
    check_eq("irq0_next_win", 32'(irq_out[0]), 32'd0);
    go_to_cycle(121); check_eq("irq0_pre3", 32'(irq_out[0]), 32'd0);

    // PERIOD write on the expiry edge: reload still uses the old period.
    mmio_wr(ch_addr(0, O_PERIOD), 32'd10);
    check_eq("irq0_rise3", 32'(irq_out[0]), 32'd1);
    mmio_rd("next_oldper", ch_addr(0, O_NEXT),   32'd49, 1'b1);
    mmio_rd("period_new",  ch_addr(0, O_PERIOD), 32'd10, 1'b1);
    go_to_cycle(172);
    mmio_rd("ack0_np1", ch_addr(0, O_ACK), ack_word(1'b1, 8'd1, 1'b0), 1'b1);
    go_to_cycle(182);
    mmio_rd("ack0_np2", ch_addr(0, O_ACK), ack_word(1'b1, 8'd2, 1'b0), 1'b1);

    // Disable while pending: irq drops, overrun kept, countdown freezes.
    go_to_cycle(189);
    mmio_wr(ch_addr(0, O_CTRL), 32'd0);
    check_eq("irq0_dis", 32'(irq_out[0]), 32'd0);
    mmio_rd("ack0_dis",   ch_addr(0, O_ACK),  ack_word(1'b0, 8'd2, 1'b0), 1'b1);
    mmio_rd("next0_frz1", ch_addr(0, O_NEXT), 32'd1, 1'b1);
    mmio_rd("next0_frz2", ch_addr(0, O_NEXT), 32'd1, 1'b1);

    // Out-of-map accesses.
    mmio_rd("oom_hi", BASE + 32'h44, 32'd0, 1'b0);
    mmio_rd("oom_lo", BASE - 32'h4,  32'd0, 1'b0);
    mmio_wr(BASE + 32'h44, 32'hFFFF_FFFF);
    mmio_wr(BASE - 32'h4,  32'h0000_0003);
    mmio_wr(BASE + 32'h40, 32'h0000_0000);
    mmio_rd("oom_ctrl0",   ch_addr(0, O_CTRL),   32'd0,  1'b1);
    mmio_rd("oom_period0", ch_addr(0, O_PERIOD), 32'd10, 1'b1);
    mmio_rd("oom_next0",   ch_addr(0, O_NEXT),   32'd1,  1'b1);
    mmio_rd("cycle_late",  ch_addr(4, O_CTRL),   32'(tb_cyc), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
